// File: rtl/mod_inv.sv
// Sequential modular inverse res = a^-1 mod n using binary extended Euclid,
// one reduction step per clock, with a start/done handshake and held result.
module mod_inv #(
  parameter int LEN = 2048
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] n,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [LEN-1:0] res
);

  localparam int unsigned WDOG = 4 * LEN + 4;
  localparam int          CW   = $clog2(WDOG + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t         r_state;
  logic [LEN-1:0] r_u, r_v, r_n;
  logic [LEN:0]   r_x1, r_x2;
  logic [CW-1:0]  r_cnt;
  logic           r_err_p, r_sel_x1;
  logic           r_busy, r_done, r_err;
  logic [LEN-1:0] r_res;

  logic [LEN:0]   w_n_ext;
  logic [LEN:0]   w_x1_half, w_x2_half, w_x1_sub, w_x2_sub;
  logic           w_bad_ops;

  // x1/x2 stay in [0, n-1], so x+n fits in LEN+1 bits and nothing is lost
  always_comb begin
    w_n_ext   = {1'b0, r_n};
    w_x1_half = r_x1[0] ? ((r_x1 + w_n_ext) >> 1) : (r_x1 >> 1);
    w_x2_half = r_x2[0] ? ((r_x2 + w_n_ext) >> 1) : (r_x2 >> 1);
    w_x1_sub  = (r_x1 >= r_x2) ? (r_x1 - r_x2) : (r_x1 + w_n_ext - r_x2);
    w_x2_sub  = (r_x2 >= r_x1) ? (r_x2 - r_x1) : (r_x2 + w_n_ext - r_x1);
    w_bad_ops = ~n[0] | (n < LEN'(3)) | (a == '0) | (a >= n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_u      <= '0;
      r_v      <= '0;
      r_n      <= '0;
      r_x1     <= '0;
      r_x2     <= '0;
      r_cnt    <= '0;
      r_err_p  <= 1'b0;
      r_sel_x1 <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_res    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_u      <= a;
            r_v      <= n;
            r_n      <= n;
            r_x1     <= (LEN+1)'(1);
            r_x2     <= '0;
            r_cnt    <= '0;
            r_res    <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
            r_err_p  <= w_bad_ops;
            r_sel_x1 <= 1'b0;
            r_state  <= w_bad_ops ? S_FIN : S_RUN;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_u == LEN'(1)) begin
            r_sel_x1 <= 1'b1;
            r_state  <= S_FIN;
          end else if (r_v == LEN'(1)) begin
            r_sel_x1 <= 1'b0;
            r_state  <= S_FIN;
          end else if ((r_u == '0) || (r_v == '0) || (r_cnt == CW'(WDOG))) begin
            // gcd(a,n) != 1, or the watchdog tripped
            r_err_p <= 1'b1;
            r_state <= S_FIN;
          end else if (!r_u[0]) begin
            r_u  <= r_u >> 1;
            r_x1 <= w_x1_half;
          end else if (!r_v[0]) begin
            r_v  <= r_v >> 1;
            r_x2 <= w_x2_half;
          end else if (r_u >= r_v) begin
            r_u  <= r_u - r_v;
            r_x1 <= w_x1_sub;
          end else begin
            r_v  <= r_v - r_u;
            r_x2 <= w_x2_sub;
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_err   <= r_err_p;
          r_res   <= r_err_p ? '0 : (r_sel_x1 ? r_x1[LEN-1:0] : r_x2[LEN-1:0]);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;
  assign res  = r_res;

endmodule

// File: tb/tb_mod_inv.sv
// Directed and randomized checks of mod_inv at LEN=16.
module tb_mod_inv;
  localparam int LEN   = 16;
  localparam int BOUND = 4 * LEN + 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [LEN-1:0] a = '0;
  logic [LEN-1:0] n = '0;
  logic           busy, done, err;
  logic [LEN-1:0] res;

  int n_cmp = 0;
  int n_bad = 0;

  mod_inv #(.LEN(LEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .n(n),
    .busy(busy), .done(done), .err(err), .res(res)
  );

  always #5 clk = ~clk;

  function automatic longint gcd(input longint x, input longint y);
    longint t;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  // Pulse start for one edge, then count edges until done (bounded).
  task automatic run_op(input logic [LEN-1:0] ia, input logic [LEN-1:0] in_,
                        output int cyc, output bit busy_ok);
    @(negedge clk);
    a = ia; n = in_; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; busy_ok = 1'b1;
    while (!done && cyc < BOUND + 10) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    if (busy !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({busy, done, err, res} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", {busy, done, err, res});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int cyc; bit bok;
    run_op(16'd3, 16'd11, cyc, bok);
    n_cmp++; if (res !== 16'd4) begin n_bad++; $display("FAIL basic_res: got %0d want 4", res); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %0b want 0", err); end
    n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %0b want 1", bok); end
    n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL basic_latency: got %0d want 6", cyc); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({done, err, res} !== {1'b0, 1'b0, 16'd4}) begin
      n_bad++; $display("FAIL basic_hold: got done=%0b err=%0b res=%0d want 0 0 4", done, err, res);
    end
  endtask

  task automatic test_latency();
    int cyc; bit bok;
    run_op(16'd1, 16'd7, cyc, bok);
    n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL a1_latency: got %0d want 2", cyc); end
    n_cmp++; if (res !== 16'd1) begin n_bad++; $display("FAIL a1_res: got %0d want 1", res); end
    run_op(16'd3, 16'd7, cyc, bok);
    n_cmp++; if (res !== 16'd5) begin n_bad++; $display("FAIL a3n7_res: got %0d want 5", res); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL a3n7_err: got %0b want 0", err); end
  endtask

  task automatic test_boundary();
    int cyc; bit bok;
    run_op(16'd65534, 16'd65535, cyc, bok);
    n_cmp++; if (res !== 16'd65534) begin n_bad++; $display("FAIL selfinv_res: got %0d want 65534", res); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL selfinv_err: got %0b want 0", err); end
  endtask

  task automatic test_err();
    int cyc; bit bok;
    run_op(16'd6, 16'd9, cyc, bok);
    n_cmp++; if ({err, res} !== {1'b1, 16'd0}) begin n_bad++; $display("FAIL gcd3: got err=%0b res=%0d want 1 0", err, res); end
    run_op(16'd5, 16'd10, cyc, bok);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL even_n_err: got %0b want 1", err); end
    n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL even_n_latency: got %0d want 1", cyc); end
    n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL even_n_busy: got %0b want 1", bok); end
    run_op(16'd0, 16'd11, cyc, bok);
    n_cmp++; if ({err, res} !== {1'b1, 16'd0}) begin n_bad++; $display("FAIL a_zero: got err=%0b res=%0d want 1 0", err, res); end
    run_op(16'd3, 16'd11, cyc, bok);
    run_op(16'd11, 16'd11, cyc, bok);
    n_cmp++; if ({err, res} !== {1'b1, 16'd0}) begin n_bad++; $display("FAIL a_eq_n: got err=%0b res=%0d want 1 0", err, res); end
    run_op(16'd1, 16'd1, cyc, bok);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL n_small: got %0b want 1", err); end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    @(negedge clk);
    a = 16'd3; n = 16'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 16'd5; n = 16'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = '0; n = '0;
    cyc = 0;
    while (!done && cyc < BOUND + 10) begin
      @(posedge clk); #1; cyc++;
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL ignore_done: got %0b want 1", done); end
    n_cmp++; if ({err, res} !== {1'b0, 16'd4}) begin n_bad++; $display("FAIL ignore_res: got err=%0b res=%0d want 0 4", err, res); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({busy, res} !== {1'b0, 16'd4}) begin n_bad++; $display("FAIL ignore_noqueue: got busy=%0b res=%0d want 0 4", busy, res); end
  endtask

  task automatic test_reset_midrun();
    int cyc; bit bok;
    @(negedge clk);
    a = 16'd3; n = 16'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, err, res} !== '0) begin
      n_bad++; $display("FAIL midrun_reset: got %h want 0", {busy, done, err, res});
    end
    @(negedge clk); rst_n = 1'b1;
    run_op(16'd3, 16'd7, cyc, bok);
    n_cmp++; if ({err, res} !== {1'b0, 16'd5}) begin n_bad++; $display("FAIL after_reset: got err=%0b res=%0d want 0 5", err, res); end
  endtask

  task automatic test_random();
    int cyc; bit bok;
    longint la, ln, g;
    logic [LEN-1:0] ra, rn;
    for (int i = 0; i < 1000; i++) begin
      rn = LEN'($urandom_range(65535, 3)) | 16'd1;
      ra = LEN'($urandom_range(int'(rn) - 1, 1));
      run_op(ra, rn, cyc, bok);
      la = longint'(ra); ln = longint'(rn);
      g = gcd(la, ln);
      n_cmp++;
      if (g == 1) begin
        if (err !== 1'b0 || res == '0 || res >= rn || ((la * longint'(res)) % ln) != 1) begin
          n_bad++; $display("FAIL rand_inv a=%0d n=%0d: got err=%0b res=%0d want inverse", ra, rn, err, res);
        end
      end else begin
        if ({err, res} !== {1'b1, 16'd0}) begin
          n_bad++; $display("FAIL rand_gcd a=%0d n=%0d: got err=%0b res=%0d want 1 0", ra, rn, err, res);
        end
      end
      n_cmp++;
      if (cyc > BOUND || !bok) begin
        n_bad++; $display("FAIL rand_cycles a=%0d n=%0d: got cyc=%0d busy_ok=%0b want <=%0d 1", ra, rn, cyc, bok, BOUND);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_boundary();
    test_err();
    test_busy_ignore();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
